// File: rtl/fp16_pkg.sv
// fp16_pkg: fp16 (1/5/10) type, field widths and a truncating adder.
// Used by fp16_add_arbiter and its testbench.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;

    // Truncating add, no Inf/NaN, no subnormals.
    // A zero magnitude on either side passes the other operand through.
    function automatic fp16_t fp16_add(fp16_t a, fp16_t b);
        fp16_t                  x;
        fp16_t                  y;
        fp16_t                  r;
        logic [EXP_W-1:0]       dexp;
        logic [MAN_W:0]         fx;
        logic [MAN_W:0]         fy;
        logic [MAN_W+1:0]       s;
        logic signed [EXP_W+1:0] e;
        r    = FP16_ZERO;
        x    = a;
        y    = b;
        dexp = '0;
        fx   = '0;
        fy   = '0;
        s    = '0;
        e    = '0;
        if (a[14:0] == 15'd0) begin
            r = b;
        end else if (b[14:0] == 15'd0) begin
            r = a;
        end else if (a[14:0] == b[14:0] && a[15] != b[15]) begin
            r = FP16_ZERO;
        end else begin
            // x is the larger magnitude, so a difference never goes negative
            if (a[14:0] < b[14:0]) begin
                x = b;
                y = a;
            end
            dexp = x[14:10] - y[14:10];
            fx   = {1'b1, x[9:0]};
            fy   = {1'b1, y[9:0]} >> dexp;
            e    = {2'b00, x[14:10]};
            if (x[15] == y[15]) begin
                s = {1'b0, fx} + {1'b0, fy};
                if (s[MAN_W+1]) begin
                    s = s >> 1;
                    e = e + 7'sd1;
                end
            end else begin
                s = {1'b0, fx} - {1'b0, fy};
                for (int i = 0; i < MAN_W; i++) begin
                    if (!s[MAN_W]) begin
                        s = s << 1;
                        e = e - 7'sd1;
                    end
                end
            end
            if (e < 0)
                r = FP16_ZERO;
            else
                r = {x[15], e[EXP_W-1:0], s[MAN_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fp16_add_arbiter_if.sv
// fp16_add_arbiter_if: requester lanes, result channel and busy flag.
// master = requesters/consumer side, slave = the arbiter.
interface fp16_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic [15:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with an internal pointer.
// Ports: clk, reset, req (vector), en, gnt (one-hot), gnt_id (index).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);
    localparam int IW = ID_W + 1;

    logic [ID_W-1:0] rr_ptr;
    logic [IW-1:0]   idx;
    logic            found;

    // First valid lane at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + IW'(i);
            if (idx >= IW'(NUM_REQ))
                idx = idx - IW'(NUM_REQ);
            if (en && !found && req[idx[ID_W-1:0]]) begin
                found               = 1'b1;
                gnt[idx[ID_W-1:0]]  = 1'b1;
                gnt_id              = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (found) begin
            if (gnt_id == ID_W'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_id + ID_W'(1);
        end
    end
endmodule

// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: shares one fp16 adder among NUM_REQ lanes, round-robin.
// Ports: clk, reset (sync, active high), bus (slave: req_*, res_*, busy).
module fp16_add_arbiter
    import fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    fp16_add_arbiter_if.slave   bus
);
    logic               can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    fp16_t              op_a;
    fp16_t              op_b;
    logic               res_valid_q;
    fp16_t              res_data_q;
    logic [ID_W-1:0]    res_id_q;

    // A consumed result frees the register in the same edge
    assign can_accept = !reset && (!res_valid_q || bus.res_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req_valid),
        .en     (can_accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign op_a = bus.req_a[16*gnt_id +: 16];
    assign op_b = bus.req_b[16*gnt_id +: 16];

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= FP16_ZERO;
            res_id_q    <= '0;
        end else if (|gnt) begin
            res_valid_q <= 1'b1;
            res_data_q  <= fp16_add(op_a, op_b);
            res_id_q    <= gnt_id;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = res_valid_q || (|bus.req_valid);
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// tb_fp16_add_arbiter: directed self-checking bench for fp16_add_arbiter.
// Scenario tasks run in sequence from one initial block.
module tb_fp16_add_arbiter;
    import fp16_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fp16_add_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    fp16_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold an unaccepted request stable
    for (genvar g = 0; g < N; g++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (reset)
            (bus.req_valid[g] && !bus.req_ready[g]) |=>
            (bus.req_valid[g]
             && $stable(bus.req_a[16*g +: 16])
             && $stable(bus.req_b[16*g +: 16])));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, still %0d cmp", n_cmp);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input fp16_t a, input fp16_t b);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 0000", bus.req_ready);
        end
        n_cmp++;
        if (bus.res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid: got %b want 0", bus.res_valid);
        end
        n_cmp++;
        if (bus.res_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_data: got %h want 0000", bus.res_data);
        end
        n_cmp++;
        if (bus.res_id !== 2'd0) begin
            n_err++;
            $display("FAIL rst_id: got %0d want 0", bus.res_id);
        end
        n_cmp++;
        if (dut.u_arb.rr_ptr !== 2'd0) begin
            n_err++;
            $display("FAIL rst_ptr: got %0d want 0", dut.u_arb.rr_ptr);
        end
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_busy: got %b want 1", bus.busy);
        end
        bus.req_valid = '0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single;
        bus.res_ready = 1'b1;
        set_lane(2, 16'h3C00, 16'h3C00);
        bus.req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_ready: got %b want 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h4000
            || bus.res_id !== 2'd2) begin
            n_err++;
            $display("FAIL single_res: got v%b %h id%0d want v1 4000 id2",
                     bus.res_valid, bus.res_data, bus.res_id);
        end
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 16'h4000) begin
            n_err++;
            $display("FAIL single_clear: got v%b %h want v0 4000",
                     bus.res_valid, bus.res_data);
        end
    endtask

    task automatic test_arith;
        fp16_t va [5] = '{16'h4000, 16'h3C00, 16'h0000, 16'h4200, 16'h0400};
        fp16_t vb [5] = '{16'h3C00, 16'hBC00, 16'hC500, 16'hBC00, 16'h8000};
        fp16_t vs [5] = '{16'h4200, 16'h0000, 16'hC500, 16'h4000, 16'h0400};
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_lane(0, va[k], vb[k]);
            bus.req_valid = 4'b0001;
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0001) begin
                n_err++;
                $display("FAIL arith_ready[%0d]: got %b want 0001",
                         k, bus.req_ready);
            end
            tick();
            bus.req_valid = '0;
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== vs[k]) begin
                n_err++;
                $display("FAIL arith[%0d] %h+%h: got v%b %h want v1 %h",
                         k, va[k], vb[k], bus.res_valid, bus.res_data, vs[k]);
            end
        end
        tick();
    endtask

    task automatic test_fairness;
        int cnt [N];
        int exp_l;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            set_lane(i, 16'h3C00, 16'h3C00);
        end
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            exp_l = c % N;
            #1;
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i]) cnt[i]++;
            n_cmp++;
            if (bus.req_ready !== 4'(1 << exp_l)) begin
                n_err++;
                $display("FAIL fair_gnt[%0d]: got %b want lane %0d",
                         c, bus.req_ready, exp_l);
            end
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(exp_l)
                || bus.res_data !== 16'h4000) begin
                n_err++;
                $display("FAIL fair_res[%0d]: got v%b id%0d %h want v1 id%0d 4000",
                         c, bus.res_valid, bus.res_id, bus.res_data, exp_l);
            end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (cnt[i] !== 10) begin
                n_err++;
                $display("FAIL fair_cnt[%0d]: got %0d want 10", i, cnt[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure;
        set_lane(0, 16'h3C00, 16'h3C00);
        set_lane(1, 16'h3C00, 16'h4000);
        set_lane(2, 16'h3C00, 16'hBC00);
        set_lane(3, 16'h3C00, 16'h0000);
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1111;
        tick();
        bus.res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b want 0000",
                         c, bus.req_ready);
            end
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0
                || bus.res_data !== 16'h4000) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v%b id%0d %h want v1 id0 4000",
                         c, bus.res_valid, bus.res_id, bus.res_data);
            end
            n_cmp++;
            if (dut.u_arb.rr_ptr !== 2'd1) begin
                n_err++;
                $display("FAIL bp_ptr[%0d]: got %0d want 1",
                         c, dut.u_arb.rr_ptr);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release: got %b want 0010", bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1
            || bus.res_data !== 16'h4200) begin
            n_err++;
            $display("FAIL bp_next: got v%b id%0d %h want v1 id1 4200",
                     bus.res_valid, bus.res_id, bus.res_data);
        end
        do_reset();
    endtask

    task automatic test_wrap_skip;
        int order [4] = '{3, 1, 3, 1};
        bus.res_ready = 1'b1;
        set_lane(2, 16'h3C00, 16'h3C00);
        bus.req_valid = 4'b0100;
        tick();
        set_lane(1, 16'h4000, 16'h3C00);
        set_lane(3, 16'h3C00, 16'h3C00);
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'(1 << order[k])) begin
                n_err++;
                $display("FAIL wrap_gnt[%0d]: got %b want lane %0d",
                         k, bus.req_ready, order[k]);
            end
            n_cmp++;
            if ((bus.req_ready & 4'b0101) !== 4'b0000) begin
                n_err++;
                $display("FAIL wrap_skip[%0d]: got %b want lanes 0,2 low",
                         k, bus.req_ready);
            end
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(order[k])) begin
                n_err++;
                $display("FAIL wrap_res[%0d]: got v%b id%0d want v1 id%0d",
                         k, bus.res_valid, bus.res_id, order[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid;
        bus.res_ready = 1'b1;
        set_lane(0, 16'h3C00, 16'h3C00);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h4000) begin
            n_err++;
            $display("FAIL mid_pre: got v%b %h want v1 4000",
                     bus.res_valid, bus.res_data);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_rst: got v%b %h want v0 0000",
                     bus.res_valid, bus.res_data);
        end
        reset = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < N; i++)
            set_lane(i, 16'h3C00, 16'h3C00);
        bus.req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_first: got %b want 0001", bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0) begin
            n_err++;
            $display("FAIL mid_res: got v%b id%0d want v1 id0",
                     bus.res_valid, bus.res_id);
        end
        do_reset();
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_arith();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp16_add_arbiter.md
Name: fp16_add_arbiter

Overview:
- Round-robin scheduler that shares one combinational fp16 (1/5/10) adder among NUM_REQ requesters, e.g. parallel CNN partial-sum lanes.
- Each requester offers an operand pair with a valid/ready handshake.
- At most one pair is granted per cycle. Its sum is captured in a single output register and returned with the winner's index.
- The output channel supports backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the result index, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i set: requester i presents an operand pair.
- req_a  in  16*NUM_REQ  operand A; lane i occupies bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot or zero; bit i set means lane i's pair is accepted this cycle.
- res_valid  out  1  result register holds a result.
- res_data  out  16  fp16 sum.
- res_id  out  ID_W  index of the requester that produced res_data.
- res_ready  in  1  consumer accepts the result this cycle.
- busy  out  1  res_valid OR any req_valid bit set.

Behaviour:
- Reset values: res_valid=0, res_data=16'h0000, res_id=0, round-robin pointer rr_ptr=0. req_ready is 0 while reset is high. Reset wins over every other event, including a pending undelivered result, which is discarded.
- Acceptance condition: can_accept = !res_valid || res_ready. This allows full throughput of one op per cycle.
- Grant:
  - When can_accept is true, the lowest index at or after rr_ptr (wrapping modulo NUM_REQ) with req_valid set wins.
  - req_ready is asserted for the winner only. It is combinational from req_valid, rr_ptr, res_valid and res_ready.
  - req_ready does not depend on the requester's operand values.
- On a handshake for lane g (req_valid[g] && req_ready[g]), at the next edge:
  - res_data = fp16_add(req_a[g], req_b[g]); res_id = g; res_valid = 1.
  - rr_ptr = (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the handshake to res_valid.
- Result cleared: res_ready with no new handshake gives res_valid=0 next cycle; res_data and res_id keep their last values.
- Simultaneous consume and accept: the new result replaces the old one in the same edge, with no bubble.
- Stall: while res_valid=1 and res_ready=0:
  - res_valid, res_data and res_id hold stable.
  - req_ready=0 on all lanes.
  - rr_ptr holds.
- No request (no req_valid set): rr_ptr holds.
- Requester rules: a requester keeps req_valid and its operands stable until accepted. An unaccepted request may not be withdrawn. The bench checks this with an assertion; the DUT does not check it.
- Adder arithmetic (the fp16_add function), all truncating with no rounding:
  - A==0 gives B; B==0 gives A.
  - Equal magnitude with opposite sign gives 16'h0000.
  - Otherwise, align the smaller exponent by right-shifting the {1,mantissa} fraction.
  - Same sign: add; on carry, shift right 1 and increment the exponent.
  - Different sign: subtract, take the sign of the difference, then normalise left by up to 10 positions.
  - A negative resulting exponent gives 16'h0000.
  - No Inf/NaN handling; exponent 31 is treated as an ordinary exponent.

Decomposition:
- Package fp16_pkg holds:
  - typedef fp16_t (16-bit) and field widths EXP_W=5, MAN_W=10.
  - constant FP16_ZERO=16'h0000.
  - function fp16_add.
- One natural sub-module, rr_arbiter (NUM_REQ):
  - inputs: request vector, enable (can_accept); output: one-hot grant.
  - owns the rr_ptr register with synchronous reset; the pointer advances only when a grant is issued.
- The top level holds the operand mux, the adder call and the output register/handshake.

Test Plan:
- Single request: lane 2 offers 3C00+3C00 with res_ready=1. req_ready[2] is high the same cycle; next cycle res_valid=1, res_data=4000, res_id=2. The cycle after, res_valid=0.
- Arithmetic corners on lane 0:
  - 4000+3C00 gives 4200.
  - 3C00+BC00 gives 0000.
  - 0000+C500 gives C500.
  - 4200+BC00 gives 4000.
  - 0400+8000 gives 0400.
- Fairness: all 4 lanes continuously valid, res_ready=1. Grants follow 0,1,2,3,0,1… with one result per cycle; over 40 cycles each lane receives exactly 10 grants.
- Backpressure: hold res_ready=0 for 5 cycles after a result. res_data, res_id and res_valid stay constant, req_ready stays 0000 and rr_ptr does not move. When res_ready rises, the next lane is granted in that same cycle.
- Pointer wrap and skip: rr_ptr=3, only lanes 1 and 3 valid. Grant order is 3,1,3,1; lanes 0 and 2 are never readied.
- Reset mid-stream: assert reset while res_valid=1 and res_ready=0. Next cycle res_valid=0 and res_data=0000. After release, lanes 0..3 all valid results in lane 0 being granted first.
